// File: rtl/axi_arbiter.sv
// -----------------------------------------------------------------------------
// axi_arbiter
//
// Round-robin arbiter between N requesters (C load, A load, B load,
// write-back) and a single memory engine. One request is outstanding at a
// time. The winner's select/address/length are latched and presented to the
// engine. A watchdog aborts a transfer that never finishes.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   req_valid[N]   : per-requester request, held until req_ready
//   req_sel[3N]    : per-requester one-hot buffer select {B,A,C}
//   req_addr[AW*N] : per-requester start address
//   req_len[LW*N]  : per-requester beat count (0 = nothing to transfer)
//   req_ready[N]   : one-cycle accept pulse to the winner
//   req_done[N]    : one-cycle completion pulse to the winner
//   mem_req_valid  : one-cycle issue pulse to the memory engine
//   mem_sel/addr/len : latched fields of the current grant
//   mem_finish     : one-cycle completion pulse from the memory engine
//   busy           : high whenever the FSM is not idle
//   timeout_err    : sticky flag, set when a transfer is aborted
//   err_clr        : clears timeout_err (a simultaneous set wins)
//
// States
//   IDLE  | no transaction; arbitrate among valid requesters
//   ISSUE | accept the winner; launch it unless its length is zero
//   WAIT  | wait for mem_finish or the watchdog to expire
// -----------------------------------------------------------------------------
module axi_arbiter #(
    parameter int N       = 4,
    parameter int AW      = 32,
    parameter int LW      = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [3*N-1:0]    req_sel,
    input  logic [AW*N-1:0]   req_addr,
    input  logic [LW*N-1:0]   req_len,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      req_done,
    output logic              mem_req_valid,
    output logic [2:0]        mem_sel,
    output logic [AW-1:0]     mem_addr,
    output logic [LW-1:0]     mem_len,
    input  logic              mem_finish,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = PW + 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   win_inc;
    logic [CW-1:0]   cnt;

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [SW-1:0]   rr_sum;
    logic [2:0]      grant_sel;
    logic [AW-1:0]   grant_addr;
    logic [LW-1:0]   grant_len;

    logic            load_grant;
    logic            finish_ok;
    logic            timeout_hit;
    logic            complete;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    // rr_sum is one bit wider than ptr so ptr+i never overflows before wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int i = 0; i < N; i++) begin
            rr_sum = {1'b0, ptr} + SW'(i);
            if (rr_sum >= SW'(N)) begin
                rr_sum = rr_sum - SW'(N);
            end
            if (!grant_found && req_valid[rr_sum[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_sum[PW-1:0];
            end
        end
    end

    // Field mux for the candidate winner.
    always_comb begin
        grant_sel  = '0;
        grant_addr = '0;
        grant_len  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == PW'(i)) begin
                grant_sel  = req_sel[3*i +: 3];
                grant_addr = req_addr[AW*i +: AW];
                grant_len  = req_len[LW*i +: LW];
            end
        end
    end

    assign win_inc = (win == IDX_LAST) ? '0 : win + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        load_grant    = 1'b0;
        finish_ok     = 1'b0;
        timeout_hit   = 1'b0;
        req_ready     = '0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    load_grant = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                req_ready[win] = 1'b1;
                if (mem_len != '0) begin
                    mem_req_valid = 1'b1;
                    state_nxt     = WAIT;
                end else begin
                    // Nothing to move: complete immediately without the engine.
                    finish_ok = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                // A finish on the watchdog's last cycle counts as success.
                if (mem_finish) begin
                    finish_ok = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign complete = finish_ok | timeout_hit;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            win         <= '0;
            cnt         <= '0;
            mem_sel     <= '0;
            mem_addr    <= '0;
            mem_len     <= '0;
            req_done    <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_done <= '0;

            if (load_grant) begin
                win      <= grant_idx;
                mem_sel  <= grant_sel;
                mem_addr <= grant_addr;
                mem_len  <= grant_len;
            end

            if (complete) begin
                req_done[win] <= 1'b1;
                ptr           <= win_inc;
            end

            // Counts WAIT cycles; holds 0 on WAIT entry.
            if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter
//
// Scenario tasks drive the arbiter and compare its outputs against a
// behavioural picture of the protocol: the winner is found by a plain
// modular search from a tracked round-robin pointer, and timing follows the
// stated latencies (issue one cycle after request, done one cycle after
// finish, abort on the 8th WAIT cycle with TIMEOUT=8).
// -----------------------------------------------------------------------------
module tb_axi_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [3*N-1:0]    req_sel;
    logic [AW*N-1:0]   req_addr;
    logic [LW*N-1:0]   req_len;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_done;
    logic              mem_req_valid;
    logic [2:0]        mem_sel;
    logic [AW-1:0]     mem_addr;
    logic [LW-1:0]     mem_len;
    logic              mem_finish;
    logic              busy;
    logic              timeout_err;
    logic              err_clr;

    logic [2:0]        r_sel  [N];
    logic [AW-1:0]     r_addr [N];
    logic [LW-1:0]     r_len  [N];

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;

    axi_arbiter #(.N(N), .AW(AW), .LW(LW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_sel      (req_sel),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .mem_req_valid(mem_req_valid),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_len      (mem_len),
        .mem_finish   (mem_finish),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_sel  = '0;
        req_addr = '0;
        req_len  = '0;
        for (int i = 0; i < N; i++) begin
            req_sel[3*i +: 3]   = r_sel[i];
            req_addr[AW*i +: AW] = r_addr[i];
            req_len[LW*i +: LW]  = r_len[i];
        end
    end

    // Winner = first requester at or after p, modulo N.
    function automatic int model_pick(input int p, input logic [N-1:0] m);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (p + i) % N;
            if (((m >> k) & 4'b0001) != 4'b0000) return k;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        mem_finish = 1'b0;
        err_clr    = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_sel[i]  = 3'b001;
            r_addr[i] = 32'h1000 * (i + 1);
            r_len[i]  = 16'd4;
        end
        step();
        step();
        rst       = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({req_ready, req_done, mem_req_valid, busy, timeout_err} !== '0)
            $display("FAIL reset_ctrl got ready=%b done=%b mrv=%b busy=%b terr=%b want all 0",
                     req_ready, req_done, mem_req_valid, busy, timeout_err);
        else n_pass++;
        n_checks++;
        if ({mem_sel, mem_addr, mem_len} !== '0)
            $display("FAIL reset_mem got sel=%b addr=%h len=%0d want 0", mem_sel, mem_addr, mem_len);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        r_sel[0] = 3'b001; r_addr[0] = 32'h100; r_len[0] = 16'd16;
        req_valid = 4'b0001;                       // cycle t
        step();                                    // t+1
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready);
        else n_pass++;
        n_checks++;
        if (mem_req_valid !== 1'b1) $display("FAIL single_mrv got %b want 1", mem_req_valid);
        else n_pass++;
        n_checks++;
        if (mem_addr !== 32'h100 || mem_len !== 16'd16 || mem_sel !== 3'b001)
            $display("FAIL single_fields got addr=%h len=%0d sel=%b want 100/16/001", mem_addr, mem_len, mem_sel);
        else n_pass++;
        step();                                    // t+2
        req_valid = '0;
        step();                                    // t+3
        step();                                    // t+4
        step();                                    // t+5
        n_checks++;
        if (req_done !== 4'b0000 || busy !== 1'b1)
            $display("FAIL single_wait got done=%b busy=%b want 0000/1", req_done, busy);
        else n_pass++;
        mem_finish = 1'b1;
        step();                                    // t+6
        mem_finish = 1'b0;
        n_checks++;
        if (req_done !== 4'b0001) $display("FAIL single_done got %b want 0001", req_done);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL single_idle got busy=%b want 0", busy);
        else n_pass++;
        step();
        n_checks++;
        if (req_done !== 4'b0000) $display("FAIL single_done_pulse got %b want 0000", req_done);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int n;
        int w;
        do_reset();
        for (int i = 0; i < N; i++) r_len[i] = 16'd4;
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = model_pick(model_ptr, req_valid);
            n = 0;
            while (req_ready === 4'b0000 && n < 20) begin
                step();
                n++;
            end
            n_checks++;
            if (n != 1) $display("FAIL rr_spacing grant %0d got %0d cycles want 1", g, n);
            else n_pass++;
            n_checks++;
            if (req_ready !== onehot(w) || mem_addr !== r_addr[w])
                $display("FAIL rr_grant %0d got ready=%b addr=%h want %b/%h",
                         g, req_ready, mem_addr, onehot(w), r_addr[w]);
            else n_pass++;
            step();
            step();
            step();
            mem_finish = 1'b1;                    // issue + 3
            step();
            mem_finish = 1'b0;
            n_checks++;
            if (req_done !== onehot(w)) $display("FAIL rr_done %0d got %b want %b", g, req_done, onehot(w));
            else n_pass++;
            model_ptr = (w + 1) % N;
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_zero_len();
        do_reset();
        r_sel[2] = 3'b100; r_addr[2] = 32'h2000; r_len[2] = 16'd0;
        req_valid = 4'b0100;
        step();
        n_checks++;
        if (req_ready !== 4'b0100 || mem_req_valid !== 1'b0)
            $display("FAIL zero_issue got ready=%b mrv=%b want 0100/0", req_ready, mem_req_valid);
        else n_pass++;
        req_valid = '0;
        step();
        n_checks++;
        if (req_done !== 4'b0100 || busy !== 1'b0)
            $display("FAIL zero_done got done=%b busy=%b want 0100/0", req_done, busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        r_len[0] = 16'd5;
        req_valid = 4'b0001;
        step();
        n_checks++;
        if (mem_req_valid !== 1'b1) $display("FAIL to_issue got mrv=%b want 1", mem_req_valid);
        else n_pass++;
        req_valid = '0;
        for (int k = 0; k < TO; k++) begin
            step();
            n_checks++;
            if (req_done !== 4'b0000 || timeout_err !== 1'b0)
                $display("FAIL to_early wait %0d got done=%b terr=%b want 0000/0", k, req_done, timeout_err);
            else n_pass++;
        end
        step();                                    // WAIT entry + 8
        n_checks++;
        if (req_done !== 4'b0001 || timeout_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL to_fire got done=%b terr=%b busy=%b want 0001/1/0", req_done, timeout_err, busy);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (timeout_err !== 1'b1) $display("FAIL to_sticky got %b want 1", timeout_err);
            else n_pass++;
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL to_clear got %b want 0", timeout_err);
        else n_pass++;

        // err_clr on the very cycle the watchdog fires: set wins
        r_len[1] = 16'd3;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        for (int k = 0; k < TO; k++) begin
            step();
            err_clr = (k == TO - 1);
        end
        step();
        err_clr = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b1 || req_done !== 4'b0010)
            $display("FAIL to_set_wins got terr=%b done=%b want 1/0010", timeout_err, req_done);
        else n_pass++;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // mem_finish on the last WAIT cycle: normal completion
        r_len[2] = 16'd2;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        for (int k = 0; k < TO; k++) begin
            step();
            mem_finish = (k == TO - 1);
        end
        step();
        mem_finish = 1'b0;
        n_checks++;
        if (timeout_err !== 1'b0 || req_done !== 4'b0100)
            $display("FAIL to_finish_tie got terr=%b done=%b want 0/0100", timeout_err, req_done);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        mem_finish = 1'b1;
        step();
        mem_finish = 1'b0;                        // ptr now 2
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        step();                                    // in WAIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({req_ready, req_done, mem_req_valid, busy, timeout_err, mem_sel, mem_addr, mem_len} !== '0)
            $display("FAIL rstwait_outputs got ready=%b done=%b mrv=%b busy=%b addr=%h want all 0",
                     req_ready, req_done, mem_req_valid, busy, mem_addr);
        else n_pass++;
        mem_finish = 1'b1;
        step();
        mem_finish = 1'b0;
        n_checks++;
        if (req_done !== 4'b0000 || busy !== 1'b0)
            $display("FAIL rstwait_stray got done=%b busy=%b want 0000/0", req_done, busy);
        else n_pass++;
        step();
        n_checks++;
        if (req_done !== 4'b0000) $display("FAIL rstwait_nodone got %b want 0000", req_done);
        else n_pass++;
        req_valid = 4'b1111;
        step();
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL rstwait_ptr got %b want 0001", req_ready);
        else n_pass++;
        req_valid = '0;
        step();
        mem_finish = 1'b1;
        step();
        mem_finish = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int w;
        int d;
        int last;
        bit to;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                r_sel[i]  = 3'(1 << $urandom_range(0, 2));
                r_addr[i] = $urandom();
                r_len[i]  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
            end
            w = model_pick(model_ptr, mask);
            req_valid = mask;
            step();
            n_checks++;
            if (req_ready !== onehot(w) || mem_req_valid !== (r_len[w] != 16'd0))
                $display("FAIL rnd_issue it %0d got ready=%b mrv=%b want %b/%b",
                         it, req_ready, mem_req_valid, onehot(w), (r_len[w] != 16'd0));
            else n_pass++;
            n_checks++;
            if (mem_addr !== r_addr[w] || mem_len !== r_len[w] || mem_sel !== r_sel[w])
                $display("FAIL rnd_fields it %0d got %h/%0d/%b want %h/%0d/%b",
                         it, mem_addr, mem_len, mem_sel, r_addr[w], r_len[w], r_sel[w]);
            else n_pass++;
            req_valid = '0;
            if (r_len[w] == 16'd0) begin
                step();
                n_checks++;
                if (req_done !== onehot(w)) $display("FAIL rnd_zero it %0d got %b want %b", it, req_done, onehot(w));
                else n_pass++;
            end else begin
                d    = $urandom_range(0, 9);
                to   = (d > TO - 1);
                last = to ? TO - 1 : d;
                for (int k = 0; k <= last; k++) begin
                    step();
                    mem_finish = (k == d);
                    n_checks++;
                    if (req_done !== 4'b0000 || timeout_err !== 1'b0 || busy !== 1'b1)
                        $display("FAIL rnd_wait it %0d k %0d got done=%b terr=%b busy=%b want 0000/0/1",
                                 it, k, req_done, timeout_err, busy);
                    else n_pass++;
                end
                step();
                mem_finish = 1'b0;
                n_checks++;
                if (req_done !== onehot(w) || timeout_err !== to || busy !== 1'b0)
                    $display("FAIL rnd_done it %0d got done=%b terr=%b busy=%b want %b/%b/0",
                             it, req_done, timeout_err, busy, onehot(w), to);
                else n_pass++;
                if (to) begin
                    repeat (d - TO) step();
                    mem_finish = 1'b1;             // arrives in IDLE: ignored
                    step();
                    mem_finish = 1'b0;
                    n_checks++;
                    if (req_done !== 4'b0000 || busy !== 1'b0)
                        $display("FAIL rnd_stray it %0d got done=%b busy=%b want 0000/0", it, req_done, busy);
                    else n_pass++;
                    err_clr = 1'b1;
                    step();
                    err_clr = 1'b0;
                    n_checks++;
                    if (timeout_err !== 1'b0) $display("FAIL rnd_clear it %0d got %b want 0", it, timeout_err);
                    else n_pass++;
                end
            end
            model_ptr = (w + 1) % N;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (C load, A load, B load, write-back).
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width.
REQ-003 The block SHALL have parameter LW, default 16, meaning the burst-length width in beats.
REQ-004 The block SHALL have parameter TIMEOUT, default 4096, meaning the maximum number of WAIT cycles before a request is aborted.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, width N: per-requester request, held until req_ready.
REQ-008 The block SHALL have port req_sel, input, width 3*N: per-requester buffer select, one-hot {B,A,C}.
REQ-009 The block SHALL have port req_addr, input, width AW*N: per-requester start address.
REQ-010 The block SHALL have port req_len, input, width LW*N: per-requester beat count.
REQ-011 The block SHALL have port req_ready, output, width N: one-cycle accept pulse.
REQ-012 The block SHALL have port req_done, output, width N: one-cycle completion pulse.
REQ-013 The block SHALL have port mem_req_valid, output, width 1: one-cycle issue pulse to the memory engine.
REQ-014 The block SHALL have port mem_sel, output, width 3: latched select of the granted request.
REQ-015 The block SHALL have port mem_addr, output, width AW: latched address of the granted request.
REQ-016 The block SHALL have port mem_len, output, width LW: latched length of the granted request.
REQ-017 The block SHALL have port mem_finish, input, width 1: one-cycle pulse from the memory engine when the transfer is complete.
REQ-018 The block SHALL have port busy, output, width 1: high in every state except IDLE.
REQ-019 The block SHALL have port timeout_err, output, width 1: sticky timeout flag.
REQ-020 The block SHALL have port err_clr, input, width 1: clears timeout_err.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, ISSUE and WAIT; only one request SHALL be outstanding at a time.
REQ-022 In IDLE with any req_valid bit high, the block SHALL select the first set bit searching from index ptr upward with wrap-around modulo N, latch that requester's sel/addr/len into mem_* and its index into win, and go to ISSUE.
REQ-023 In ISSUE, req_ready[win] SHALL be 1 for exactly one cycle; if the latched len != 0, mem_req_valid SHALL be 1 for that same cycle and the next state SHALL be WAIT.
REQ-024 In ISSUE with latched len == 0, mem_req_valid SHALL stay 0, req_done[win] SHALL pulse on the next cycle, ptr SHALL advance, and the next state SHALL be IDLE.
REQ-025 Latency: req_valid first sampled high in cycle t with the block idle -> req_ready and mem_req_valid high in cycle t+1.
REQ-026 In WAIT, mem_finish high in cycle f SHALL produce req_done[win]=1 in cycle f+1 and state IDLE in cycle f+1; ptr SHALL become (win+1) mod N.
REQ-027 Arbitration SHALL occur in the IDLE cycle f+1, so the back-to-back mem_req_valid spacing is finish cycle +2.
REQ-028 mem_finish SHALL be ignored in IDLE and ISSUE.
REQ-029 The WAIT counter SHALL start at 0 on WAIT entry and increment each WAIT cycle; reaching TIMEOUT-1 without mem_finish SHALL set timeout_err, pulse req_done[win], advance ptr, and return to IDLE.
REQ-030 mem_finish in the same cycle as timeout SHALL be treated as normal completion, with timeout_err not set.
REQ-031 err_clr SHALL clear timeout_err; if set and clear coincide, set SHALL win.
REQ-032 Non-granted requesters SHALL see req_ready=0 and req_done=0; at most one bit of req_ready and req_done SHALL be set in any cycle.
REQ-033 mem_sel/mem_addr/mem_len SHALL hold their latched values from ISSUE through WAIT and until the next grant.
REQ-034 req_valid dropping without req_ready SHALL be legal; it is simply not granted.

Reset
REQ-035 rst SHALL force state IDLE, ptr=0, win=0, counter=0, and all outputs 0 (req_ready, req_done, mem_req_valid, mem_sel, mem_addr, mem_len, busy, timeout_err).
REQ-036 rst during ISSUE or WAIT SHALL abandon the transaction with no req_done pulse, and a later stray mem_finish SHALL be ignored.

Verification
REQ-037 Single request: req_valid=0001, sel=001, addr=0x100, len=16 -> cycle t+1 req_ready=0001, mem_req_valid=1, mem_addr=0x100; mem_finish at t+5 -> req_done=0001 at t+6.
REQ-038 Round robin: all four valid and held, each finished 3 cycles after issue -> grant order 0,1,2,3,0; no requester is granted twice before the others.
REQ-039 Zero length: len=0 on requester 2 -> req_ready=0100 with mem_req_valid=0, then req_done=0100 the following cycle.
REQ-040 Timeout: TIMEOUT=8 and no mem_finish -> timeout_err=1 and req_done pulses 8 cycles after WAIT entry; timeout_err stays high until err_clr, and set wins on a simultaneous set and clear.
REQ-041 Reset in WAIT: rst pulse then mem_finish -> no req_done, all outputs 0, ptr=0.
